// File: rtl/ternary_pingpong_sequencer.sv
// Multi-buffer ring sequencer: lets the loader fill one SRAM buffer while the engine streams another.
// Optional stall-cycle performance counter enabled by defining TFAB_SEQ_PERF_EN.
module ternary_pingpong_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_BUF    = 2,
    parameter int BUF_WORDS  = 2048,
    parameter int IDX_W      = $clog2(NUM_BUF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cfg_depth,
    input  logic [7:0]            cfg_stride,
    input  logic [15:0]           cfg_frames,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  ld_commit,
    output logic [IDX_W-1:0]      ld_buf,
    output logic                  ld_full,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    output logic                  eng_enable,
    output logic                  eng_last,
    output logic                  frame_done,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  err_overflow,
    output logic [31:0]           stall_cycles
);

    localparam int OFF_W = $clog2(BUF_WORDS);
    localparam logic [IDX_W:0]      FULL_FILL   = (IDX_W+1)'(NUM_BUF);
    localparam logic [ADDR_WIDTH:0] DEPTH_MAX   = (ADDR_WIDTH+1)'(BUF_WORDS);
    localparam logic [ADDR_WIDTH:0] DEPTH_ONE   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT_BUF, STREAM, DRAIN} state_t;

    state_t                state;
    logic [IDX_W-1:0]      wr_ptr;
    logic [IDX_W-1:0]      rd_ptr;
    logic [IDX_W:0]        fill;
    logic [ADDR_WIDTH-1:0] depth_m1;
    logic [7:0]            stride;
    logic [15:0]           frames;
    logic [ADDR_WIDTH-1:0] word;
    logic [OFF_W-1:0]      offset;
    logic                  rd_last;

    logic [ADDR_WIDTH:0]   depth_eff;
    logic [7:0]            stride_eff;
    logic [OFF_W-1:0]      next_offset;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  flush;
    logic                  release_buf;
    logic                  commit_ok;
    logic                  last_frame;

    always_comb begin
        depth_eff = {1'b0, cfg_depth};
        if (cfg_depth == '0)
            depth_eff = DEPTH_ONE;
        else if ({1'b0, cfg_depth} > DEPTH_MAX)
            depth_eff = DEPTH_MAX;
    end

    assign stride_eff  = (cfg_stride == 8'd0) ? 8'd1 : cfg_stride;
    // Power-of-two buffer size makes the in-buffer wrap a plain truncation.
    assign next_offset = offset + OFF_W'(stride);
    assign base_addr   = ADDR_WIDTH'(rd_ptr) << OFF_W;

    assign flush       = abort && (state != IDLE);
    assign release_buf = (state == DRAIN) && !abort;
    assign commit_ok   = ld_commit && ((fill != FULL_FILL) || release_buf) && !flush;
    assign last_frame  = (frames != 16'd0) && (({1'b0, frame_count} + 17'd1) == {1'b0, frames});

    assign ld_buf  = wr_ptr;
    assign ld_full = (fill == FULL_FILL);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            err_overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (commit_ok)
                wr_ptr <= wr_ptr + IDX_W'(1);
            if (release_buf)
                rd_ptr <= rd_ptr + IDX_W'(1);
            if (commit_ok && !release_buf)
                fill <= fill + (IDX_W+1)'(1);
            else if (!commit_ok && release_buf)
                fill <= fill - (IDX_W+1)'(1);
            if (ld_commit && !commit_ok)
                err_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            depth_m1    <= '0;
            stride      <= '0;
            frames      <= '0;
            word        <= '0;
            offset      <= '0;
            rd_last     <= 1'b0;
            rd_addr     <= '0;
            rd_en       <= 1'b0;
            eng_enable  <= 1'b0;
            eng_last    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            eng_enable <= rd_en;
            eng_last   <= rd_en && rd_last;
            if (flush) begin
                state      <= IDLE;
                rd_en      <= 1'b0;
                rd_last    <= 1'b0;
                eng_enable <= 1'b0;
                eng_last   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            depth_m1    <= ADDR_WIDTH'(depth_eff - DEPTH_ONE);
                            stride      <= stride_eff;
                            frames      <= cfg_frames;
                            frame_count <= '0;
                            state       <= WAIT_BUF;
                        end
                    end
                    WAIT_BUF: begin
                        if (fill != '0) begin
                            word    <= '0;
                            offset  <= '0;
                            rd_addr <= base_addr;
                            rd_en   <= 1'b1;
                            rd_last <= (depth_m1 == '0);
                            state   <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (word == depth_m1) begin
                            rd_en      <= 1'b0;
                            rd_last    <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DRAIN;
                        end else begin
                            word    <= word + ADDR_WIDTH'(1);
                            offset  <= next_offset;
                            rd_addr <= base_addr | ADDR_WIDTH'(next_offset);
                            rd_en   <= 1'b1;
                            rd_last <= ((word + ADDR_WIDTH'(1)) == depth_m1);
                        end
                    end
                    DRAIN: begin
                        if (frame_count != 16'hFFFF)
                            frame_count <= frame_count + 16'd1;
                        state <= last_frame ? IDLE : WAIT_BUF;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef TFAB_SEQ_PERF_EN
    // Counts only true starvation: waiting for the loader with an empty ring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (state == IDLE && start && !abort)
            stall_cycles <= '0;
        else if (state == WAIT_BUF && fill == '0 && !abort && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ternary_pingpong_sequencer.sv
// Directed self-checking bench for ternary_pingpong_sequencer (NUM_BUF=2, BUF_WORDS=2048).
// Covers preload, stride wrap, overflow, starvation, abort and release/commit collision.
module tb_ternary_pingpong_sequencer;

    logic        clk;
    logic        reset;
    logic [11:0] cfg_depth;
    logic [7:0]  cfg_stride;
    logic [15:0] cfg_frames;
    logic        start;
    logic        abort;
    logic        ld_commit;
    logic [0:0]  ld_buf;
    logic        ld_full;
    logic [11:0] rd_addr;
    logic        rd_en;
    logic        eng_enable;
    logic        eng_last;
    logic        frame_done;
    logic        busy;
    logic [15:0] frame_count;
    logic        err_overflow;
    logic [31:0] stall_cycles;

`ifdef TFAB_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int vec_count = 0;
    int err_count = 0;
    int n;
    int dones;
    bit chk_full;

    logic [11:0] preload_addr [0:7] = '{12'd0, 12'd1, 12'd2, 12'd3,
                                        12'd2048, 12'd2049, 12'd2050, 12'd2051};
    logic [11:0] stride_addr  [0:9] = '{12'd0, 12'd255, 12'd510, 12'd765, 12'd1020,
                                        12'd1275, 12'd1530, 12'd1785, 12'd2040, 12'd247};

    ternary_pingpong_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_depth    (cfg_depth),
        .cfg_stride   (cfg_stride),
        .cfg_frames   (cfg_frames),
        .start        (start),
        .abort        (abort),
        .ld_commit    (ld_commit),
        .ld_buf       (ld_buf),
        .ld_full      (ld_full),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .eng_enable   (eng_enable),
        .eng_last     (eng_last),
        .frame_done   (frame_done),
        .busy         (busy),
        .frame_count  (frame_count),
        .err_overflow (err_overflow),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task waitCycles(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Inputs are held for exactly one rising edge, then released.
    task applyStimulus(input logic commit, input logic go, input logic stop);
        ld_commit = commit;
        start     = go;
        abort     = stop;
        waitCycles(1);
        ld_commit = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
    endtask

    task doReset();
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
    endtask

    task setConfig(input logic [11:0] depth, input logic [7:0] stride, input logic [15:0] frames);
        cfg_depth  = depth;
        cfg_stride = stride;
        cfg_frames = frames;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ld_commit = 1'b0;
        setConfig(12'd4, 8'd1, 16'd2);
        waitCycles(2);

        $display("[TB] reset values");
        checkOutput("rst_rd_en", 32'(rd_en), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ld_buf", 32'(ld_buf), 0);
        checkOutput("rst_ld_full", 32'(ld_full), 0);
        checkOutput("rst_frame_done", 32'(frame_done), 0);
        checkOutput("rst_err_overflow", 32'(err_overflow), 0);
        checkOutput("rst_stall", stall_cycles, 0);
        reset = 1'b0;

        $display("[TB] preload two buffers, two frames of depth 4");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pre_ld_buf1", 32'(ld_buf), 1);
        checkOutput("pre_ld_full1", 32'(ld_full), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pre_ld_buf2", 32'(ld_buf), 0);
        checkOutput("pre_ld_full2", 32'(ld_full), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pre_busy", 32'(busy), 1);
        checkOutput("pre_no_rd_yet", 32'(rd_en), 0);
        n = 0; dones = 0; chk_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            waitCycles(1);
            if (chk_full) begin
                checkOutput("pre_ld_full_after_release", 32'(ld_full), 0);
                chk_full = 1'b0;
            end
            if (rd_en) begin
                if (n == 0) checkOutput("pre_first_rd_cycle", 32'(i), 0);
                if (n < 8) checkOutput("pre_rd_addr", 32'(rd_addr), 32'(preload_addr[n]));
                n++;
            end
            if (frame_done) begin
                checkOutput("pre_done_eng_en_last", 32'({eng_enable, eng_last}), 3);
                if (dones == 0) begin
                    checkOutput("pre_ld_full_before_release", 32'(ld_full), 1);
                    chk_full = 1'b1;
                end
                dones++;
            end
        end
        checkOutput("pre_words", 32'(n), 8);
        checkOutput("pre_frame_dones", 32'(dones), 2);
        checkOutput("pre_frame_count", 32'(frame_count), 2);
        checkOutput("pre_idle", 32'(busy), 0);

        $display("[TB] stride wrap, stride 255 depth 10");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        setConfig(12'd10, 8'd255, 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            waitCycles(1);
            if (rd_en) begin
                if (n < 10) checkOutput("str_rd_addr", 32'(rd_addr), 32'(stride_addr[n]));
                n++;
            end
        end
        checkOutput("str_words", 32'(n), 10);
        checkOutput("str_frame_count", 32'(frame_count), 1);
        checkOutput("str_idle", 32'(busy), 0);

        $display("[TB] overflow with no run");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ovf_full1", 32'(ld_full), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ovf_full2", 32'(ld_full), 1);
        checkOutput("ovf_err2", 32'(err_overflow), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ovf_err3", 32'(err_overflow), 1);
        checkOutput("ovf_full3", 32'(ld_full), 1);
        checkOutput("ovf_ld_buf3", 32'(ld_buf), 0);

        $display("[TB] starvation in free-run");
        doReset();
        setConfig(12'd2, 8'd1, 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(5);
        checkOutput("stv_busy", 32'(busy), 1);
        checkOutput("stv_rd_en", 32'(rd_en), 0);
        checkOutput("stv_stall5", stall_cycles, PERF ? 32'd5 : 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("stv_rd_en_at_commit", 32'(rd_en), 0);
        waitCycles(1);
        checkOutput("stv_rd_en_after", 32'(rd_en), 1);
        checkOutput("stv_rd_addr", 32'(rd_addr), 0);
        checkOutput("stv_stall6", stall_cycles, PERF ? 32'd6 : 32'd0);

        $display("[TB] abort mid-stream");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        setConfig(12'd100, 8'd1, 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(41);
        checkOutput("abt_rd_addr40", 32'(rd_addr), 40);
        checkOutput("abt_eng_en_before", 32'(eng_enable), 1);
        checkOutput("abt_ld_buf_before", 32'(ld_buf), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abt_rd_en", 32'(rd_en), 0);
        checkOutput("abt_busy", 32'(busy), 0);
        checkOutput("abt_ld_buf", 32'(ld_buf), 0);
        checkOutput("abt_ld_full", 32'(ld_full), 0);
        checkOutput("abt_frame_done", 32'(frame_done), 0);
        waitCycles(1);
        checkOutput("abt_eng_en_after", 32'(eng_enable), 0);
        checkOutput("abt_frame_done2", 32'(frame_done), 0);
        checkOutput("abt_frame_count", 32'(frame_count), 0);

        $display("[TB] release and commit in the same cycle");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        setConfig(12'd2, 8'd1, 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("sim_in_drain", 32'(frame_done), 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sim_ld_full", 32'(ld_full), 1);
        checkOutput("sim_ld_buf", 32'(ld_buf), 1);
        checkOutput("sim_err", 32'(err_overflow), 0);
        checkOutput("sim_frame_count", 32'(frame_count), 1);
        waitCycles(1);
        checkOutput("sim_rd_en", 32'(rd_en), 1);
        checkOutput("sim_rd_addr", 32'(rd_addr), 2048);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
